condicionador_botoes: RTL

//   Input stage between the 4 raw push-buttons and the game datapath.
//   Per-bit 2-FF synchroniser, pattern debounce FSM, stable held button pattern (-> datapath botoes).
//   One-cycle press pulse for the control unit; presses gated by habilita.

---
 rtl/condicionador_botoes_pkg.sv | 26 ++
 rtl/condicionador_botoes_sincronizador.sv | 26 ++
 rtl/condicionador_botoes.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and debounce helpers.
// Also used by builds that define COND_BOTOES_REJEITA_MULTI_EN (multi-button rejection).
package condicionador_botoes_pkg;

  localparam int NUM_BOTOES = 4;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  // Number of clock cycles a pattern must stay stable before it is accepted.
  function automatic int deb_ciclos(input int clock_freq, input int debounce_ms);
    return clock_freq / 1000 * debounce_ms;
  endfunction

  // True when more than one button is set (v & (v-1) clears the lowest set bit).
  function automatic logic multi_bit(input logic [NUM_BOTOES-1:0] v);
    logic [NUM_BOTOES-1:0] um;
    um = {{(NUM_BOTOES-1){1'b0}}, 1'b1};
    return (v & (v - um)) != '0;
  endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador.sv
// Per-bit two flip-flop synchroniser for asynchronous inputs.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchroniser, debounce FSM, held pattern and press/release pulses.
// Optional COND_BOTOES_REJEITA_MULTI_EN: reject multi-button patterns with an erro_multi pulse.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_raw,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       jogada_feita,
  output logic       soltou,
  output logic       erro_multi,
  output logic [1:0] db_estado
);

  localparam int DEB_CICLOS = deb_ciclos(CLOCK_FREQ, DEBOUNCE_MS);
  localparam int CNT_W      = $clog2(DEB_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CICLOS - 1);

  logic [3:0]       sync;
  estado_t          state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       botoes_q, botoes_d;
  logic             jog_q, jog_d;
  logic             sol_q, sol_d;
`ifdef COND_BOTOES_REJEITA_MULTI_EN
  logic             err_q, err_d;
  logic             multi_prev_q;
`endif

  sincronizador_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (botoes_raw),
    .q_o   (sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      cand_q   <= '0;
      cnt_q    <= '0;
      botoes_q <= '0;
      jog_q    <= 1'b0;
      sol_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      botoes_q <= botoes_d;
      jog_q    <= jog_d;
      sol_q    <= sol_d;
    end
  end

`ifdef COND_BOTOES_REJEITA_MULTI_EN
  // multi_prev_q lets OCIOSO flag a multi-button attempt only on its first cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q        <= 1'b0;
      multi_prev_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      multi_prev_q <= multi_bit(sync);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    botoes_d = botoes_q;
    jog_d    = 1'b0;
    sol_d    = 1'b0;
`ifdef COND_BOTOES_REJEITA_MULTI_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      OCIOSO: begin
`ifdef COND_BOTOES_REJEITA_MULTI_EN
        if (multi_bit(sync)) begin
          err_d = !multi_prev_q;
        end else if (sync != '0 && habilita) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = FILTRA_PRESS;
        end
`else
        if (sync != '0 && habilita) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = FILTRA_PRESS;
        end
`endif
      end
      FILTRA_PRESS: begin
        if (sync == '0 || !habilita) begin
          state_d = OCIOSO;
          cnt_d   = '0;
`ifdef COND_BOTOES_REJEITA_MULTI_EN
        end else if (multi_bit(sync)) begin
          state_d = OCIOSO;
          cnt_d   = '0;
          err_d   = 1'b1;
`endif
        end else if (sync != cand_q) begin
          cand_d = sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = PRESSIONADO;
          cnt_d    = '0;
          botoes_d = cand_q;
          jog_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        // Pattern changes while held are ignored; only a full release counts.
        if (sync == '0) begin
          state_d = FILTRA_SOLTA;
          cnt_d   = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (sync != '0) begin
          state_d = PRESSIONADO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = OCIOSO;
          cnt_d    = '0;
          botoes_d = '0;
          sol_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OCIOSO;
        cnt_d   = '0;
      end
    endcase
  end

  assign botoes       = botoes_q;
  assign jogada_feita = jog_q;
  assign soltou       = sol_q;
  assign db_estado    = state_q;
`ifdef COND_BOTOES_REJEITA_MULTI_EN
  assign erro_multi   = err_q;
`else
  assign erro_multi   = 1'b0;
`endif

endmodule
